// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
//   Shared definitions for the five-stage MIPS pipeline register bank:
//   reset/bubble defaults, instruction field positions, the per-stage
//   {instruction, link value} record and small helpers on it.
package mips_pipe_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  // sll $0,$0,0
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Instruction field positions
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc8;
  } stage_t;

  // Contents of a stage holding an injected bubble (also the reset value).
  function automatic stage_t bubbleStage(input logic [31:0] nopWord);
    stage_t s;
    s.ins = nopWord;
    s.pc8 = '0;
    return s;
  endfunction

  function automatic logic [5:0] opField(input logic [31:0] ins);
    return ins[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [5:0] functField(input logic [31:0] ins);
    return ins[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   One pipeline stage register carrying {instruction word, PC+8}.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset, loads the bubble value
//     en     load d when high, hold when low
//     clr    load the bubble value (takes priority over en)
//     d      incoming stage record
//     q      registered stage record
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  logic   clr,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= bubbleStage(NOP_WORD);
    end else if (clr) begin
      q <= bubbleStage(NOP_WORD);
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ins_tracker.sv
// pipe_ins_tracker
//   Instruction/PC pipeline register bank for the five-stage MIPS core.
//   Holds the fetch PC and carries each instruction word and its PC+8 link
//   value through D, E, M and W. A stall freezes PC and D and injects a
//   bubble into E; a redirect (ignored while stalled) loads the fetch PC
//   with the word-aligned target at the next edge. The delay-slot word
//   fetched in the redirect cycle still enters D.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     InsF                instruction read from IM at PCF
//     stall, redirect     hazard-unit stall, taken branch/jump in D
//     targetD             redirect target (bits [1:0] ignored)
//     PCF                 fetch address
//     InsD/E/M/W          stage instruction words
//     PC8D/E/M/W          stage link values (fetch PC + 8)
//     bubbleE             InsE holds an injected bubble
//   Build option PIPE_PERF_CNT_EN adds wrapping 32-bit counters
//     cycle_cnt, stall_cnt, redirect_cnt (unstalled redirects).
module pipe_ins_tracker
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InsF,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] targetD,
  output logic [31:0] PCF,
  output logic [31:0] InsD,
  output logic [31:0] InsE,
  output logic [31:0] InsM,
  output logic [31:0] InsW,
  output logic [31:0] PC8D,
  output logic [31:0] PC8E,
  output logic [31:0] PC8M,
  output logic [31:0] PC8W,
  output logic        bubbleE
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  logic [31:0] pcNext;
  stage_t      stageF, stageD, stageE, stageM, stageW;

  // Alignment bits of the target are dropped by design.
  logic        unusedTargetLsbs;
  assign unusedTargetLsbs = ^targetD[1:0];

  // Fetch PC and next-PC selection; stall has priority over redirect.
  always_comb begin
    pcNext = PCF + 32'd4;
    if (stall) begin
      pcNext = PCF;
    end else if (redirect) begin
      pcNext = {targetD[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= pcNext;
    end
  end

  always_comb begin
    stageF.ins = InsF;
    stageF.pc8 = PCF + 32'd8;
  end

  pipe_stage_reg #(.NOP_WORD(NOP_WORD)) uStageD (
    .clk(clk), .reset(reset), .en(~stall), .clr(1'b0), .d(stageF), .q(stageD)
  );

  pipe_stage_reg #(.NOP_WORD(NOP_WORD)) uStageE (
    .clk(clk), .reset(reset), .en(1'b1), .clr(stall), .d(stageD), .q(stageE)
  );

  pipe_stage_reg #(.NOP_WORD(NOP_WORD)) uStageM (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(stageE), .q(stageM)
  );

  pipe_stage_reg #(.NOP_WORD(NOP_WORD)) uStageW (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(stageM), .q(stageW)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubbleE <= 1'b0;
    end else begin
      bubbleE <= stall;
    end
  end

  always_comb begin
    InsD = stageD.ins;
    InsE = stageE.ins;
    InsM = stageM.ins;
    InsW = stageW.ins;
    PC8D = stageD.pc8;
    PC8E = stageE.pc8;
    PC8M = stageM.pc8;
    PC8W = stageW.pc8;
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt    <= '0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (redirect && !stall) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
